// File: rtl/fifo_rd_pack.sv
// fifo_rd_pack: read-side consumer of the async FIFO. Pops show-ahead entries,
// packs PACK of them little-endian into one wide valid/ready beat, and emits a
// partial beat with a lane-keep mask on flush.
module fifo_rd_pack #(
    parameter int DSIZE = 8,
    parameter int PACK  = 4,
    parameter int CSIZE = 16
) (
    input  logic                    rclk,
    input  logic                    rrst,
    input  logic                    rempty,
    input  logic [DSIZE-1:0]        rdata,
    output logic                    rinc,
    input  logic                    flush,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DSIZE*PACK-1:0]   out_data,
    output logic [PACK-1:0]         out_keep,
    output logic                    out_last,
    output logic [CSIZE-1:0]        beat_cnt
);

    localparam int IW = $clog2(PACK);
    localparam logic [IW-1:0] IDX_LAST = IW'(PACK - 1);

    typedef enum logic {
        S_FILL,
        S_FLUSH
    } state_t;

    state_t                  state, state_n;
    logic [DSIZE*PACK-1:0]   acc, acc_n;
    logic [IW-1:0]           idx, idx_n;
    logic                    slot_free;
    logic                    load;
    logic [DSIZE*PACK-1:0]   load_data;
    logic [PACK-1:0]         load_keep;
    logic                    load_last;
    logic [DSIZE*PACK-1:0]   pop_word;
    logic [PACK-1:0]         part_keep;
    int unsigned             idx_u;

    assign slot_free = !out_valid || out_ready;

    // The last lane may only be popped when the completed word has somewhere to go.
    assign rinc = !rrst && !rempty && (state == S_FILL) && ((idx != IDX_LAST) || slot_free);

    // Next-state, accumulator update and output-register load selection.
    always_comb begin
        state_n   = state;
        acc_n     = acc;
        idx_n     = idx;
        load      = 1'b0;
        load_data = '0;
        load_keep = '0;
        load_last = 1'b0;
        idx_u     = 32'(idx);
        part_keep = '0;
        for (int unsigned k = 0; k < PACK; k++) begin
            part_keep[k] = (k < idx_u);
        end
        pop_word = acc;
        pop_word[idx*DSIZE +: DSIZE] = rdata;

        case (state)
            S_FILL: begin
                if (rinc) begin
                    if (idx == IDX_LAST) begin
                        load      = 1'b1;
                        load_data = pop_word;
                        load_keep = '1;
                        acc_n     = '0;
                        idx_n     = '0;
                    end else begin
                        acc_n = pop_word;
                        idx_n = idx + IW'(1);
                    end
                end
                if (flush) begin
                    state_n = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (idx == '0) begin
                    state_n = S_FILL;
                end else if (slot_free) begin
                    load      = 1'b1;
                    load_data = acc;
                    load_keep = part_keep;
                    load_last = 1'b1;
                    acc_n     = '0;
                    idx_n     = '0;
                    state_n   = S_FILL;
                end
            end
            default: state_n = S_FILL;
        endcase
    end

    // State, accumulator and lane index registers.
    always_ff @(posedge rclk) begin
        if (rrst) begin
            state <= S_FILL;
            acc   <= '0;
            idx   <= '0;
        end else begin
            state <= state_n;
            acc   <= acc_n;
            idx   <= idx_n;
        end
    end

    // Output beat register and accepted-beat counter.
    always_ff @(posedge rclk) begin
        if (rrst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_keep  <= '0;
            out_last  <= 1'b0;
            beat_cnt  <= '0;
        end else begin
            if (out_valid && out_ready) begin
                beat_cnt <= beat_cnt + CSIZE'(1);
            end
            if (load) begin
                out_valid <= 1'b1;
                out_data  <= load_data;
                out_keep  <= load_keep;
                out_last  <= load_last;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fifo_rd_pack.sv
// tb_fifo_rd_pack: directed vectors for fifo_rd_pack with a queue scoreboard
// checked by an independent output monitor.
module tb_fifo_rd_pack;

    localparam int DSIZE = 8;
    localparam int PACK  = 4;
    localparam int CSIZE = 16;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } beat_t;

    logic                  rclk;
    logic                  rrst;
    logic                  rempty;
    logic [DSIZE-1:0]      rdata;
    logic                  rinc;
    logic                  flush;
    logic                  out_valid;
    logic                  out_ready;
    logic [DSIZE*PACK-1:0] out_data;
    logic [PACK-1:0]       out_keep;
    logic                  out_last;
    logic [CSIZE-1:0]      beat_cnt;

    logic [7:0] fifo_q[$];
    beat_t      exp_q[$];
    int         vectors     = 0;
    int         miscompares = 0;
    int         pops;
    logic       popped;

    fifo_rd_pack #(.DSIZE(DSIZE), .PACK(PACK), .CSIZE(CSIZE)) dut (
        .rclk      (rclk),
        .rrst      (rrst),
        .rempty    (rempty),
        .rdata     (rdata),
        .rinc      (rinc),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_keep  (out_keep),
        .out_last  (out_last),
        .beat_cnt  (beat_cnt)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic refresh();
        rempty = (fifo_q.size() == 0);
        rdata  = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
    endtask

    task automatic push(input logic [7:0] d);
        fifo_q.push_back(d);
        refresh();
    endtask

    task automatic expect_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
        beat_t b;
        b.data = d;
        b.keep = k;
        b.last = l;
        exp_q.push_back(b);
    endtask

    // Advance n clock edges, modelling the FIFO head being consumed on rinc.
    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            #1;
            popped = rinc;
            @(posedge rclk);
            #1;
            if (popped && fifo_q.size() != 0) void'(fifo_q.pop_front());
            refresh();
            #1;
        end
    endtask

    // Monitor: every accepted beat must match the head of the scoreboard.
    always @(negedge rclk) begin
        if (!rrst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_beat: got data 0x%0h keep 0x%0h last %0b, none expected",
                         out_data, out_keep, out_last);
            end else begin
                beat_t e;
                e = exp_q.pop_front();
                chk("beat_data", 64'(out_data), 64'(e.data));
                chk("beat_keep", 64'(out_keep), 64'(e.keep));
                chk("beat_last", 64'(out_last), 64'(e.last));
            end
        end
    end

    initial begin
        rrst      = 1'b1;
        flush     = 1'b1;
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) push(8'(i));
        #1;

        // Reset holds rinc low even with data available and flush asserted
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            chk("reset_rinc", 64'(rinc), 64'd0);
        end
        chk("reset_valid", 64'(out_valid), 64'd0);
        chk("reset_keep", 64'(out_keep), 64'd0);
        chk("reset_cnt", 64'(beat_cnt), 64'd0);

        // Streaming at one entry per cycle
        rrst  = 1'b0;
        flush = 1'b0;
        expect_beat(32'h04030201, 4'hF, 1'b0);
        expect_beat(32'h08070605, 4'hF, 1'b0);
        #1;
        for (int i = 0; i < 8; i++) begin
            chk("stream_rinc", 64'(rinc), 64'd1);
            cyc(1);
        end
        chk("stream_drained_rinc", 64'(rinc), 64'd0);
        cyc(1);
        chk("stream_cnt", 64'(beat_cnt), 64'd2);
        chk("stream_idle", 64'(out_valid), 64'd0);

        // Backpressure: seven pops then stall with the first beat held
        out_ready = 1'b0;
        for (int i = 1; i <= 8; i++) push(8'(i));
        expect_beat(32'h04030201, 4'hF, 1'b0);
        expect_beat(32'h08070605, 4'hF, 1'b0);
        pops = 0;
        #1;
        for (int i = 0; i < 10; i++) begin
            if (rinc) pops++;
            cyc(1);
        end
        chk("bp_pops", 64'(pops), 64'd7);
        chk("bp_stall_rinc", 64'(rinc), 64'd0);
        chk("bp_held_valid", 64'(out_valid), 64'd1);
        chk("bp_held_data", 64'(out_data), 64'h04030201);
        out_ready = 1'b1;
        #1;
        chk("bp_release_rinc", 64'(rinc), 64'd1);
        cyc(1);
        chk("bp_next_valid", 64'(out_valid), 64'd1);
        chk("bp_next_data", 64'(out_data), 64'h08070605);
        cyc(1);
        chk("bp_cnt", 64'(beat_cnt), 64'd4);

        // Partial flush of three entries
        push(8'hAA); push(8'hBB); push(8'hCC);
        expect_beat(32'h00CCBBAA, 4'h7, 1'b1);
        cyc(4);
        flush = 1'b1;
        cyc(1);
        flush = 1'b0;
        chk("flush_not_yet", 64'(out_valid), 64'd0);
        cyc(1);
        chk("flush_valid", 64'(out_valid), 64'd1);
        chk("flush_data", 64'(out_data), 64'h00CCBBAA);
        chk("flush_keep", 64'(out_keep), 64'h7);
        chk("flush_last", 64'(out_last), 64'd1);
        cyc(1);
        chk("flush_cnt", 64'(beat_cnt), 64'd5);

        // Flush with nothing accumulated emits nothing; packing resumes at lane 0
        flush = 1'b1;
        cyc(1);
        flush = 1'b0;
        cyc(2);
        chk("empty_flush_valid", 64'(out_valid), 64'd0);
        chk("empty_flush_cnt", 64'(beat_cnt), 64'd5);
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        expect_beat(32'h44332211, 4'hF, 1'b0);
        cyc(6);
        chk("resume_cnt", 64'(beat_cnt), 64'd6);

        // Flush behind a held full beat waits for acceptance
        out_ready = 1'b0;
        push(8'h51); push(8'h52); push(8'h53); push(8'h54); push(8'h61); push(8'h62);
        expect_beat(32'h54535251, 4'hF, 1'b0);
        expect_beat(32'h00006261, 4'h3, 1'b1);
        cyc(8);
        chk("held_valid", 64'(out_valid), 64'd1);
        chk("held_data", 64'(out_data), 64'h54535251);
        flush = 1'b1;
        cyc(1);
        flush = 1'b0;
        cyc(3);
        chk("held_stable_data", 64'(out_data), 64'h54535251);
        chk("held_stable_keep", 64'(out_keep), 64'hF);
        chk("held_stable_last", 64'(out_last), 64'd0);
        out_ready = 1'b1;
        cyc(1);
        chk("late_flush_valid", 64'(out_valid), 64'd1);
        chk("late_flush_data", 64'(out_data), 64'h00006261);
        chk("late_flush_keep", 64'(out_keep), 64'h3);
        chk("late_flush_last", 64'(out_last), 64'd1);
        cyc(1);
        chk("late_flush_cnt", 64'(beat_cnt), 64'd8);
        chk("late_flush_idle", 64'(out_valid), 64'd0);

        // Reset mid-operation drops the held beat and the partial accumulator
        out_ready = 1'b0;
        push(8'h71); push(8'h72); push(8'h73); push(8'h74); push(8'h75); push(8'h76);
        cyc(8);
        chk("pre_rst_valid", 64'(out_valid), 64'd1);
        chk("pre_rst_data", 64'(out_data), 64'h74737271);
        rrst = 1'b1;
        cyc(1);
        rrst = 1'b0;
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_cnt", 64'(beat_cnt), 64'd0);
        chk("mid_rst_keep", 64'(out_keep), 64'd0);
        out_ready = 1'b1;
        push(8'h81); push(8'h82); push(8'h83); push(8'h84);
        expect_beat(32'h84838281, 4'hF, 1'b0);
        cyc(6);
        chk("post_rst_cnt", 64'(beat_cnt), 64'd1);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
